// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
// Configurable oversampling UART receiver: majority-voted sampling, optional parity,
// one or two stop bits, per-frame latched configuration.
module uart_rx_cfg #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PRESC_WIDTH = 6
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic [PRESC_WIDTH-1:0] PRESCALE,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  input  logic                   STOP2,
  output logic [DATA_WIDTH-1:0]  P_DATA,
  output logic                   DATA_VALID,
  output logic                   PAR_ERR,
  output logic                   STP_ERR,
  output logic                   BUSY
);

  localparam int unsigned CNT_W = 5;
  localparam int unsigned BIT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [CNT_W-1:0]      half_q, half_d;
  logic [CNT_W-1:0]      last_q, last_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  stop2_q, stop2_d;
  logic                  arm_q, arm_d;
  logic                  s0_q, s0_d;
  logic                  s1_q, s1_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bad_q, par_bad_d;
  logic                  stp_bad_q, stp_bad_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  busy_q, busy_d;

  logic [CNT_W-1:0]      half_c, last_c;
  logic                  wrap_c, samp0_c, samp1_c, samp2_c, maj_c, last_stop_c;

  // Decode the oversampling ratio; anything other than 8 or 16 runs at 32.
  always_comb begin
    half_c = CNT_W'(16);
    last_c = CNT_W'(31);
    if (PRESCALE == PRESC_WIDTH'(8)) begin
      half_c = CNT_W'(4);
      last_c = CNT_W'(7);
    end else if (PRESCALE == PRESC_WIDTH'(16)) begin
      half_c = CNT_W'(8);
      last_c = CNT_W'(15);
    end
  end

  // Sample points around mid-bit and the 2-of-3 vote using the live third sample.
  always_comb begin
    wrap_c      = (cnt_q == last_q);
    samp0_c     = (cnt_q == half_q - CNT_W'(1));
    samp1_c     = (cnt_q == half_q);
    samp2_c     = (cnt_q == half_q + CNT_W'(1));
    maj_c       = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);
    last_stop_c = (bit_q[0] == stop2_q);
  end

  // Next-state, counters, datapath and registered output values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    half_d       = half_q;
    last_d       = last_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    stop2_d      = stop2_q;
    arm_d        = RX_IN;
    s0_d         = s0_q;
    s1_d         = s1_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    stp_bad_d    = stp_bad_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    if (state_q != S_IDLE) begin
      cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
      if (samp0_c) s0_d = RX_IN;
      if (samp1_c) s1_d = RX_IN;
    end

    case (state_q)
      S_IDLE: begin
        // The falling edge itself is edge count 0 of the start bit.
        if (arm_q && !RX_IN) begin
          state_d   = S_START;
          cnt_d     = CNT_W'(1);
          bit_d     = '0;
          half_d    = half_c;
          last_d    = last_c;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          stop2_d   = STOP2;
          par_bad_d = 1'b0;
          stp_bad_d = 1'b0;
        end
      end
      S_START: begin
        // Two high samples already decide the vote, so reject a glitch one cycle early.
        if (samp1_c && s0_q && RX_IN) begin
          state_d = S_IDLE;
        end else if (samp2_c && maj_c) begin
          state_d = S_IDLE;
        end else if (wrap_c) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (samp2_c) shift_d = {maj_c, shift_q[DATA_WIDTH-1:1]};
        if (wrap_c) begin
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (samp2_c) par_bad_d = (maj_c != ((^shift_q) ^ par_typ_q));
        if (wrap_c) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (samp2_c) begin
          if (!maj_c) stp_bad_d = 1'b1;
          if (last_stop_c) begin
            state_d   = S_IDLE;
            par_err_d = par_bad_q;
            stp_err_d = stp_bad_q | ~maj_c;
            if (!par_bad_q && !stp_bad_q && maj_c) begin
              data_valid_d = 1'b1;
              p_data_d     = shift_q;
            end
          end
        end else if (wrap_c) begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) cnt_d = '0;
    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      half_q       <= '0;
      last_q       <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      stop2_q      <= 1'b0;
      arm_q        <= 1'b0;
      s0_q         <= 1'b0;
      s1_q         <= 1'b0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      stp_bad_q    <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      half_q       <= half_d;
      last_q       <= last_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      stop2_q      <= stop2_d;
      arm_q        <= arm_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      stp_bad_q    <= stp_bad_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = data_valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;
  assign BUSY       = busy_q;

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame, legal 5..9.
REQ-002 SHALL have parameter PRESC_WIDTH, default 6, width of the PRESCALE input.
REQ-003 SHALL have port CLK  in  1  oversampling clock, frequency = PRESCALE x baud.
REQ-004 SHALL have port RST  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port RX_IN  in  1  serial line, idle high, already synchronous to CLK (no internal synchroniser).
REQ-006 SHALL have port PRESCALE  in  PRESC_WIDTH  oversampling ratio; legal 8, 16, 32; any other value is treated as 32.
REQ-007 SHALL have port PAR_EN  in  1  1 = parity bit present after data.
REQ-008 SHALL have port PAR_TYP  in  1  0 = even, 1 = odd parity.
REQ-009 SHALL have port STOP2  in  1  1 = two stop bits, 0 = one.
REQ-010 SHALL have port P_DATA  out  DATA_WIDTH  last good received word, LSB received first.
REQ-011 SHALL have port DATA_VALID  out  1  single-cycle pulse, P_DATA updated.
REQ-012 SHALL have port PAR_ERR  out  1  single-cycle pulse, parity mismatch.
REQ-013 SHALL have port STP_ERR  out  1  single-cycle pulse, a stop bit sampled 0.
REQ-014 SHALL have port BUSY  out  1  high from start-bit acceptance until return to IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, with transitions START->DATA->(PARITY if PAR_EN)->STOP->IDLE.
REQ-016 SHALL arm start detection in IDLE only after RX_IN = 1 for at least one cycle, then enter START on the first cycle RX_IN = 0 (edge count 0).
REQ-017 SHALL latch PRESCALE, PAR_EN, PAR_TYP and STOP2 on START entry; changes mid-frame are ignored until the next frame.
REQ-018 SHALL run an edge counter 0..P-1 per bit and a bit counter; take samples at edge counts P/2-1, P/2 and P/2+1; use the 2-of-3 majority as the bit value.
REQ-019 SHALL return to IDLE (glitch reject) if the start-bit majority is 1, with no flag or output change.
REQ-020 SHALL shift data bits LSB first into an internal register; P_DATA SHALL be unchanged until a good frame completes.
REQ-021 SHALL compute expected parity as XOR of data bits (even) or its inverse (odd), and flag a mismatch.
REQ-022 SHALL check every stop bit, where any majority-0 stop bit sets the stop error.
REQ-023 SHALL evaluate the frame at the final stop bit's edge count P/2+1, with outputs registered one cycle later and FSM back in IDLE that same cycle.
REQ-024 SHALL, for an N-bit frame starting at cycle 0, assert the flags at cycle (N-1)*P + P/2 + 2; for 8 data + parity + 1 stop at P = 32 this is cycle 338.
REQ-025 SHALL pulse DATA_VALID and load P_DATA only if there is no parity and no stop error.
REQ-026 SHALL pulse PAR_ERR and STP_ERR independently, both asserted together if both errors occur; DATA_VALID SHALL stay 0 on any error.
REQ-027 SHALL accept a start bit immediately after the last stop-bit sample point without loss (back-to-back frames), since the stop level re-arms detection.
REQ-028 SHALL keep BUSY = 0 in IDLE and BUSY = 1 in all other states.

Reset
REQ-029 SHALL, on RST = 0 at any time including mid-frame, immediately force IDLE, clear all counters and the shift register, and drive P_DATA = 0, DATA_VALID = 0, PAR_ERR = 0, STP_ERR = 0, BUSY = 0.
REQ-030 SHALL, after reset release with RX_IN held low, not start a frame until RX_IN has been seen high (per REQ-016).

Verification
REQ-031 SHALL verify: P = 32, even parity, 1 stop, send 0xA6 (parity bit 0) -> P_DATA = 0xA6, one DATA_VALID pulse at cycle 338, no error flags.
REQ-032 SHALL verify: P = 16, odd parity, send 0x3C with parity bit 0 (wrong) -> PAR_ERR single pulse, DATA_VALID = 0, P_DATA keeps its previous value.
REQ-033 SHALL verify: P = 8, no parity, STOP2 = 1, second stop bit driven 0 -> STP_ERR pulse; the following frame 0x55 is received correctly.
REQ-034 SHALL verify: P = 32, RX_IN low for 10 cycles then high -> BUSY returns to 0 by cycle 17 with no flags.
REQ-035 SHALL verify: P = 8, no parity, 1 stop, back-to-back 0x55 then 0x0F with no idle gap -> two DATA_VALID pulses, P_DATA = 0x55 then 0x0F.
REQ-036 SHALL verify: RST asserted during data bit 4 of a frame, RX_IN low at release -> all outputs 0, no frame until RX_IN goes high, next 0x81 frame received correctly.
